// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, optional parity.
// Flags pulse for one clock on the mid-stop sample; oData keeps the last word.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iTick16x,
    input  logic                 iRx,
    output logic [DATA_BITS-1:0] oData,
    output logic                 oValid,
    output logic                 oFrameErr,
    output logic                 oParityErr,
    output logic                 oBusy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rxs_q, rxs_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 armed_q, armed_d;
    logic                 par_err_q, par_err_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            armed_q    <= 1'b0;
            par_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rxs_q      <= rxs_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            armed_q    <= armed_d;
            par_err_q  <= par_err_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        rx_meta_d  = iRx;
        rxs_d      = rx_meta_q;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        armed_d    = armed_q;
        par_err_d  = par_err_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;

        // Illegal encodings recover immediately, independent of the tick.
        if (state_q > S_STOP) begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            armed_d    = 1'b0;
        end else if (iTick16x) begin
            case (state_q)
                S_IDLE: begin
                    if (rxs_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d    = S_START;
                        armed_d    = 1'b0;
                        tick_cnt_d = '0;
                        par_err_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            bit_idx_d = '0;
                            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        par_err_d = ((^shift_q) ^ rxs_q) != 1'(PARITY_ODD);
                        state_d   = S_STOP;
                    end
                end
                S_STOP: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        data_d     = shift_q;
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                        par_err_d  = 1'b0;
                        if (!rxs_q)         ferr_d  = 1'b1;
                        else if (par_err_q) perr_d  = 1'b1;
                        else                valid_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign oData      = data_q;
    assign oValid     = valid_q;
    assign oFrameErr  = ferr_q;
    assign oParityErr = perr_q;
    assign oBusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: 8N1 instance plus an 8E1 instance.
// Stimulus pushes expected frames; per-DUT monitors pop on every output pulse.
module tb_uart_rx;

    typedef struct {
        int         kind;   // 0 = valid, 1 = frame error, 2 = parity error
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] d0, d1;
    logic       v0, fe0, pe0, b0;
    logic       v1, fe1, pe1, b1;
    int         tick_div = 0;
    int         n_checks = 0;
    int         n_err = 0;
    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] b2b_tbl [10] = '{8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E,
                                 8'h12, 8'hC3, 8'h99, 8'h40, 8'h0F};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div <= (tick_div == 9) ? 0 : tick_div + 1;
        tick     <= (tick_div == 9);
    end

    uart_rx u_dut (
        .iClk(clk), .iRst_n(rst_n), .iTick16x(tick), .iRx(rx0),
        .oData(d0), .oValid(v0), .oFrameErr(fe0), .oParityErr(pe0), .oBusy(b0)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .iClk(clk), .iRst_n(rst_n), .iTick16x(tick), .iRx(rx1),
        .oData(d1), .oValid(v1), .oFrameErr(fe1), .oParityErr(pe1), .oBusy(b1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic score(input int which, input logic v, input logic fe,
                         input logic pe, input logic [7:0] d);
        exp_t e;
        int   kind;
        if (which == 0) begin
            if (q0.size() == 0) begin chk("unexpected_pulse_dut0", 1, 0); return; end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin chk("unexpected_pulse_dut1", 1, 0); return; end
            e = q1.pop_front();
        end
        kind = v ? 0 : (fe ? 1 : 2);
        chk("single_flag", int'(v) + int'(fe) + int'(pe), 1);
        chk("pulse_kind", kind, e.kind);
        chk("rx_data", int'(d), int'(e.data));
        $display("dut%0d frame: kind=%0d data=0x%02h (expected kind=%0d data=0x%02h)",
                 which, kind, d, e.kind, e.data);
    endtask

    always @(negedge clk) if (rst_n && (v0 || fe0 || pe0)) score(0, v0, fe0, pe0, d0);
    always @(negedge clk) if (rst_n && (v1 || fe1 || pe1)) score(1, v1, fe1, pe1, d1);

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int tgt, input logic v);
        if (tgt == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic push(input int tgt, input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        if (tgt == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // One frame, 160 clocks per bit; rst_bit >= 0 pulses reset mid-way through that data bit.
    task automatic send_frame(input int tgt, input logic [7:0] d, input bit par_en,
                              input bit par_bit, input bit stop_bit, input int rst_bit);
        set_line(tgt, 1'b0);
        wait_clks(160);
        for (int i = 0; i < 8; i++) begin
            set_line(tgt, d[i]);
            if (i == rst_bit) begin
                wait_clks(80);
                rst_n = 1'b0;
                wait_clks(2);
                rst_n = 1'b1;
                @(negedge clk);
                chk("busy_after_reset", int'(b0), 0);
                chk("data_after_reset", int'(d0), 0);
                wait_clks(77);
            end else begin
                wait_clks(160);
            end
        end
        if (par_en) begin
            set_line(tgt, par_bit);
            wait_clks(160);
        end
        set_line(tgt, stop_bit);
        wait_clks(160);
    endtask

    initial begin
        wait_clks(5);
        @(negedge clk);
        chk("reset_busy", int'(b0), 0);
        chk("reset_valid", int'(v0), 0);
        chk("reset_frame_err", int'(fe0), 0);
        chk("reset_parity_err", int'(pe0), 0);
        chk("reset_data", int'(d0), 0);
        rst_n = 1'b1;
        wait_clks(320);

        push(0, 0, 8'h55); send_frame(0, 8'h55, 0, 0, 1, -1);
        push(0, 0, 8'hA3); send_frame(0, 8'hA3, 0, 0, 1, -1);
        wait_clks(320);

        // Short low glitch: START is entered, then rejected at mid-bit.
        rx0 = 1'b0;
        wait_clks(30);
        @(negedge clk);
        chk("glitch_busy_during", int'(b0), 1);
        rx0 = 1'b1;
        wait_clks(200);
        @(negedge clk);
        chk("glitch_busy_after", int'(b0), 0);
        chk("glitch_data_held", int'(d0), 8'hA3);

        // Low stop bit followed by a 30-bit break.
        push(0, 1, 8'h3C); send_frame(0, 8'h3C, 0, 0, 0, -1);
        wait_clks(30 * 160 - 160);
        @(negedge clk);
        chk("break_busy", int'(b0), 0);
        chk("break_data", int'(d0), 8'h3C);
        rx0 = 1'b1;
        wait_clks(320);
        push(0, 0, 8'h81); send_frame(0, 8'h81, 0, 0, 1, -1);
        wait_clks(320);

        // Reset during data bit 4 abandons the frame silently.
        send_frame(0, 8'hF0, 0, 0, 1, 4);
        wait_clks(320);
        @(negedge clk);
        chk("abandoned_busy", int'(b0), 0);
        chk("abandoned_data", int'(d0), 0);
        push(0, 0, 8'hF0); send_frame(0, 8'hF0, 0, 0, 1, -1);
        wait_clks(320);

        for (int i = 0; i < 10; i++) begin
            push(0, 0, b2b_tbl[i]);
            send_frame(0, b2b_tbl[i], 0, 0, 1, -1);
        end
        wait_clks(320);

        // Even parity: 0x07 has three ones, so parity bit 1 is correct.
        push(1, 0, 8'h07); send_frame(1, 8'h07, 1, 1, 1, -1);
        wait_clks(320);
        push(1, 2, 8'h07); send_frame(1, 8'h07, 1, 0, 1, -1);
        wait_clks(320);
        @(negedge clk);
        chk("parity_data", int'(d1), 8'h07);
        chk("parity_busy", int'(b1), 0);

        chk("dut0_missing_frames", q0.size(), 0);
        chk("dut1_missing_frames", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
